mem_port_arbiter: RTL and testbench

//  Shares one single-ported memory between the CPU fetch stage (IF, read-only) and the MEM stage (DM, read/write).

---
 rtl/mem_port_arbiter.sv | 139 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch (IF) and data memory (DM).
// DM has priority; IF wins after STARVE_LIMIT contested DM grants; stalled accesses time out.
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [3:0]  dm_be,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        dm_ack,
  output logic [31:0] dm_rdata,
  output logic        ack_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
  localparam logic [9:0] TMO_LAST   = 10'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_I = 2'd1,
    WAIT_D = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t     state_r;
  logic [3:0] starve_cnt_r;
  logic [9:0] tmo_cnt_r;
  logic       grant_i_s;
  logic       grant_d_s;

  // Grant decision in IDLE: DM first unless IF has been starved too long
  always_comb begin
    grant_i_s = 1'b0;
    grant_d_s = 1'b0;
    if (state_r == IDLE) begin
      if (dm_req && (!if_req || (starve_cnt_r != STARVE_MAX))) begin
        grant_d_s = 1'b1;
      end else begin
        grant_i_s = if_req;
      end
    end else begin
      grant_i_s = 1'b0;
      grant_d_s = 1'b0;
    end
  end

  // Arbiter FSM with all outputs registered
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      starve_cnt_r <= 4'd0;
      tmo_cnt_r    <= 10'd0;
      if_ack       <= 1'b0;
      if_rdata     <= 32'd0;
      dm_ack       <= 1'b0;
      dm_rdata     <= 32'd0;
      ack_err      <= 1'b0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_be       <= 4'd0;
      mem_addr     <= 32'd0;
      mem_wdata    <= 32'd0;
    end else begin
      case (state_r)
        IDLE: begin
          tmo_cnt_r <= 10'd0;
          if (grant_d_s) begin
            state_r   <= WAIT_D;
            mem_req   <= 1'b1;
            mem_we    <= dm_we;
            mem_be    <= dm_be;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            if (if_req && (starve_cnt_r != STARVE_MAX)) begin
              starve_cnt_r <= starve_cnt_r + 4'd1;
            end
          end else if (grant_i_s) begin
            state_r      <= WAIT_I;
            mem_req      <= 1'b1;
            mem_we       <= 1'b0;
            mem_be       <= 4'hF;
            mem_addr     <= if_addr;
            mem_wdata    <= 32'd0;
            starve_cnt_r <= 4'd0;
          end
        end
        WAIT_I, WAIT_D: begin
          // Writes and aborted accesses return zero data
          if (mem_ready || (tmo_cnt_r == TMO_LAST)) begin
            state_r <= RESP;
            mem_req <= 1'b0;
            ack_err <= !mem_ready;
            if (state_r == WAIT_I) begin
              if_ack   <= 1'b1;
              if_rdata <= mem_ready ? mem_rdata : 32'd0;
            end else begin
              dm_ack   <= 1'b1;
              dm_rdata <= (mem_ready && !mem_we) ? mem_rdata : 32'd0;
            end
          end else begin
            tmo_cnt_r <= tmo_cnt_r + 10'd1;
          end
        end
        RESP: begin
          state_r   <= IDLE;
          if_ack    <= 1'b0;
          dm_ack    <= 1'b0;
          ack_err   <= 1'b0;
          mem_req   <= 1'b0;
          tmo_cnt_r <= 10'd0;
        end
        default: begin
          state_r   <= IDLE;
          if_ack    <= 1'b0;
          dm_ack    <= 1'b0;
          ack_err   <= 1'b0;
          mem_req   <= 1'b0;
          tmo_cnt_r <= 10'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (STARVE_LIMIT=4, TIMEOUT_CYCLES=8).
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        dm_req;
  logic        dm_we;
  logic [3:0]  dm_be;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  logic        ack_err;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.STARVE_LIMIT(4), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata), .ack_err(ack_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory contents: a fixed instruction at 0x100, address-derived data elsewhere
  function automatic logic [31:0] mem_model(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'h0050_0513;
    return {a[15:0], 16'hC0DE};
  endfunction

  assign mem_rdata = mem_model(mem_addr);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; if_req = 1'b1; if_addr = 32'h0000_0100;
    dm_req = 1'b0; dm_we = 1'b0; dm_be = 4'd0; dm_addr = 32'd0; dm_wdata = 32'd0;
    mem_ready = 1'b1;
    tick(); tick(); tick();
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_mem_req: got %b want 0", mem_req); end
    checks++; if ({if_ack, dm_ack, ack_err, mem_we} !== 4'b0000) begin errors++; $display("FAIL rst_flags: got %b want 0000", {if_ack, dm_ack, ack_err, mem_we}); end
    checks++; if ({mem_be, mem_addr, mem_wdata} !== 68'd0) begin errors++; $display("FAIL rst_mem_bus: got %h want 0", {mem_be, mem_addr, mem_wdata}); end
    checks++; if ({if_rdata, dm_rdata} !== 64'd0) begin errors++; $display("FAIL rst_rdata: got %h want 0", {if_rdata, dm_rdata}); end
    reset = 1'b0; if_req = 1'b0; mem_ready = 1'b0;
    tick();
  endtask

  task automatic test_fetch();
    if_req = 1'b1; if_addr = 32'h0000_0100; mem_ready = 1'b1;
    tick();
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL t1_mem_req: got %b want 1", mem_req); end
    checks++; if ({mem_we, mem_be, mem_addr} !== {1'b0, 4'hF, 32'h0000_0100}) begin errors++; $display("FAIL t1_mem_bus: got %h want %h", {mem_we, mem_be, mem_addr}, {1'b0, 4'hF, 32'h0000_0100}); end
    checks++; if (if_ack !== 1'b0) begin errors++; $display("FAIL t1_early_ack: got %b want 0", if_ack); end
    tick();
    checks++; if ({if_ack, dm_ack, ack_err, mem_req} !== 4'b1000) begin errors++; $display("FAIL t1_ack: got %b want 1000", {if_ack, dm_ack, ack_err, mem_req}); end
    checks++; if (if_rdata !== 32'h0050_0513) begin errors++; $display("FAIL t1_rdata: got %h want 00500513", if_rdata); end
    if_req = 1'b0;
    tick();
    checks++; if ({if_ack, mem_req} !== 2'b00) begin errors++; $display("FAIL t1_idle: got %b want 00", {if_ack, mem_req}); end
    checks++; if (if_rdata !== 32'h0050_0513) begin errors++; $display("FAIL t1_hold: got %h want 00500513", if_rdata); end
  endtask

  task automatic test_priority();
    if_req = 1'b1; if_addr = 32'h0000_0100;
    dm_req = 1'b1; dm_we = 1'b0; dm_be = 4'hF; dm_addr = 32'h0000_2000; mem_ready = 1'b1;
    tick();
    checks++; if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h0000_2000}) begin errors++; $display("FAIL t2_dm_first: got %h want %h", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 32'h0000_2000}); end
    tick();
    checks++; if ({dm_ack, if_ack} !== 2'b10) begin errors++; $display("FAIL t2_dm_ack: got %b want 10", {dm_ack, if_ack}); end
    checks++; if (dm_rdata !== 32'h2000_C0DE) begin errors++; $display("FAIL t2_dm_rdata: got %h want 2000c0de", dm_rdata); end
    dm_req = 1'b0;
    tick();
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL t2_idle: got %b want 0", mem_req); end
    tick();
    checks++; if ({mem_req, mem_addr} !== {1'b1, 32'h0000_0100}) begin errors++; $display("FAIL t2_if_grant: got %h want %h", {mem_req, mem_addr}, {1'b1, 32'h0000_0100}); end
    tick();
    checks++; if ({if_ack, dm_ack, if_rdata} !== {2'b10, 32'h0050_0513}) begin errors++; $display("FAIL t2_if_ack: got %h want %h", {if_ack, dm_ack, if_rdata}, {2'b10, 32'h0050_0513}); end
    if_req = 1'b0; mem_ready = 1'b0;
    tick();
  endtask

  task automatic test_write_wait();
    dm_req = 1'b1; dm_we = 1'b1; dm_be = 4'b0011; dm_addr = 32'h0000_0040; dm_wdata = 32'hDEAD_BEEF;
    mem_ready = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      tick();
      checks++;
      if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata, dm_ack} !== {1'b1, 1'b1, 4'b0011, 32'h0000_0040, 32'hDEAD_BEEF, 1'b0}) begin
        errors++; $display("FAIL t4_stable_c%0d: got %h want %h", c, {mem_req, mem_we, mem_be, mem_addr, mem_wdata, dm_ack}, {1'b1, 1'b1, 4'b0011, 32'h0000_0040, 32'hDEAD_BEEF, 1'b0});
      end
    end
    mem_ready = 1'b1;
    tick();
    checks++; if ({dm_ack, ack_err, mem_req} !== 3'b100) begin errors++; $display("FAIL t4_ack: got %b want 100", {dm_ack, ack_err, mem_req}); end
    checks++; if (dm_rdata !== 32'd0) begin errors++; $display("FAIL t4_rdata: got %h want 0", dm_rdata); end
    dm_req = 1'b0;
    tick();
    tick();
    checks++; if ({dm_ack, if_ack, mem_req, dm_rdata} !== 35'd0) begin errors++; $display("FAIL t4_stray_ready: got %h want 0", {dm_ack, if_ack, mem_req, dm_rdata}); end
    mem_ready = 1'b0; dm_we = 1'b0;
    tick();
  endtask

  task automatic test_starvation();
    int acks;
    int last;
    logic exp_if;
    acks = 0; last = 0;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_3000;
    if_req = 1'b1; if_addr = 32'h0000_0100; mem_ready = 1'b1;
    for (int c = 1; c <= 40 && acks < 10; c++) begin
      tick();
      if (if_ack || dm_ack) begin
        exp_if = (acks == 4) || (acks == 9);
        checks++; if ({if_ack, dm_ack} !== {exp_if, !exp_if}) begin errors++; $display("FAIL t3_owner_%0d: got %b want %b", acks, {if_ack, dm_ack}, {exp_if, !exp_if}); end
        checks++; if ((c - last) != ((acks == 0) ? 2 : 3)) begin errors++; $display("FAIL t3_spacing_%0d: got %0d want %0d", acks, c - last, (acks == 0) ? 2 : 3); end
        last = c;
        acks++;
        if (acks == 10) begin
          if_req = 1'b0; dm_req = 1'b0;
        end
      end
    end
    checks++; if (acks != 10) begin errors++; $display("FAIL t3_ack_count: got %0d want 10", acks); end
    mem_ready = 1'b0; if_req = 1'b0; dm_req = 1'b0;
    tick();
    checks++; if (dm_rdata !== 32'h3000_C0DE) begin errors++; $display("FAIL t3_dm_rdata: got %h want 3000c0de", dm_rdata); end
  endtask

  task automatic test_timeout();
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_0080; mem_ready = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      checks++; if ({mem_req, dm_ack} !== 2'b10) begin errors++; $display("FAIL t5_wait_c%0d: got %b want 10", c, {mem_req, dm_ack}); end
    end
    tick();
    checks++; if ({dm_ack, ack_err, mem_req, if_ack} !== 4'b1100) begin errors++; $display("FAIL t5_abort: got %b want 1100", {dm_ack, ack_err, mem_req, if_ack}); end
    checks++; if (dm_rdata !== 32'd0) begin errors++; $display("FAIL t5_rdata: got %h want 0", dm_rdata); end
    dm_req = 1'b0;
    tick();
    checks++; if ({dm_ack, ack_err, mem_req} !== 3'b000) begin errors++; $display("FAIL t5_idle: got %b want 000", {dm_ack, ack_err, mem_req}); end
  endtask

  task automatic test_mid_reset();
    int seen;
    seen = 0;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_2000; mem_ready = 1'b0;
    tick();
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL t6_wait_d: got %b want 1", mem_req); end
    reset = 1'b1;
    tick();
    reset = 1'b0; dm_req = 1'b0;
    checks++; if ({mem_req, dm_ack, if_ack, ack_err} !== 4'b0000) begin errors++; $display("FAIL t6_flags: got %b want 0000", {mem_req, dm_ack, if_ack, ack_err}); end
    checks++; if ({mem_addr, if_rdata, mem_be} !== 68'd0) begin errors++; $display("FAIL t6_regs: got %h want 0", {mem_addr, if_rdata, mem_be}); end
    mem_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (dm_ack) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL t6_no_ack: got %0d want 0", seen); end
    if_req = 1'b1; if_addr = 32'h0000_0100;
    tick();
    checks++; if ({mem_req, mem_addr} !== {1'b1, 32'h0000_0100}) begin errors++; $display("FAIL t6_if_grant: got %h want %h", {mem_req, mem_addr}, {1'b1, 32'h0000_0100}); end
    tick();
    checks++; if ({if_ack, if_rdata} !== {1'b1, 32'h0050_0513}) begin errors++; $display("FAIL t6_if_ack: got %h want %h", {if_ack, if_rdata}, {1'b1, 32'h0050_0513}); end
    if_req = 1'b0; mem_ready = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_priority();
    test_write_wait();
    test_starvation();
    test_timeout();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
